// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle RV32I core.
// Optional retired-instruction counter: define INSTRET_CNT_EN.
module multicycle_control_fsm #(
  parameter bit RESET_STATE_IDLE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  Opcode,
  input  logic [2:0]  Funct3,
  input  logic        ALUZero,
  input  logic        ALULessThan,
  input  logic        ALULessThanU,
  input  logic        MemReady,
  output logic        SrcASel,
  output logic [1:0]  SrcBSel,
  output logic [1:0]  ALUCtl,
  output logic [1:0]  ResultSrc,
  output logic        AdrSrc,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        IllegalInstr,
  output logic [31:0] InstRet
);

  typedef enum logic [4:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_AUIPC,
    S_ALUWB,
    S_BRCOMP,
    S_BRTARGET,
    S_JAL,
    S_JALR,
    S_LUI,
    S_ILLEGAL
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  state_t state;
  logic   taken;
  logic   br_cond;
  logic   br_bad;

  always_comb begin
    br_cond = 1'b0;
    br_bad  = 1'b0;
    unique case (Funct3)
      3'b000:  br_cond = ALUZero;
      3'b001:  br_cond = !ALUZero;
      3'b100:  br_cond = ALULessThan;
      3'b101:  br_cond = !ALULessThan;
      3'b110:  br_cond = ALULessThanU;
      3'b111:  br_cond = !ALULessThanU;
      default: br_bad  = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RESET_STATE_IDLE ? S_IDLE : S_FETCH;
      taken <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE:  state <= S_FETCH;
        S_FETCH: if (MemReady) state <= S_DECODE;
        S_DECODE: begin
          unique case (Opcode)
            OP_LOAD,
            OP_STORE:  state <= S_MEMADR;
            OP_R:      state <= S_EXEC_R;
            OP_I:      state <= S_EXEC_I;
            OP_BRANCH: state <= S_BRCOMP;
            OP_JAL:    state <= S_JAL;
            OP_JALR:   state <= S_JALR;
            OP_LUI:    state <= S_LUI;
            OP_AUIPC:  state <= S_AUIPC;
            default:   state <= S_ILLEGAL;
          endcase
        end
        S_MEMADR:
          state <= (Opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (MemReady) state <= S_MEMWB;
        S_MEMWRITE: if (MemReady) state <= S_FETCH;
        S_EXEC_R,
        S_EXEC_I,
        S_AUIPC:    state <= S_ALUWB;
        S_BRCOMP: begin
          taken <= br_cond && !br_bad;
          state <= S_BRTARGET;
        end
        default:    state <= S_FETCH;
      endcase
    end
  end

  // Outputs follow state, but MemReady and Funct3 shape a few same-cycle
  // strobes; reset suppresses everything so no write leaks out.
  always_comb begin
    SrcASel      = 1'b0;
    SrcBSel      = 2'b00;
    ALUCtl       = 2'b00;
    ResultSrc    = 2'b00;
    AdrSrc       = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    PCWrite      = 1'b0;
    PCSrc        = 1'b0;
    IllegalInstr = 1'b0;
    if (!reset) begin
      unique case (state)
        S_FETCH: begin
          MemRead = 1'b1;
          IRWrite = MemReady;
        end
        S_MEMADR: SrcBSel = 2'b01;
        S_MEMREAD: begin
          AdrSrc  = 1'b1;
          MemRead = 1'b1;
        end
        S_MEMWB: begin
          ResultSrc = 2'b01;
          RegWrite  = 1'b1;
          PCWrite   = 1'b1;
        end
        S_MEMWRITE: begin
          AdrSrc   = 1'b1;
          MemWrite = 1'b1;
          PCWrite  = MemReady;
        end
        S_EXEC_R: ALUCtl = 2'b10;
        S_EXEC_I: begin
          SrcBSel = 2'b01;
          ALUCtl  = 2'b10;
        end
        S_AUIPC: begin
          SrcASel = 1'b1;
          SrcBSel = 2'b01;
        end
        S_ALUWB: begin
          RegWrite = 1'b1;
          PCWrite  = 1'b1;
        end
        S_BRCOMP: begin
          ALUCtl       = 2'b01;
          IllegalInstr = br_bad;
        end
        S_BRTARGET: begin
          SrcASel = 1'b1;
          SrcBSel = 2'b01;
          PCWrite = 1'b1;
          PCSrc   = taken;
        end
        S_JAL, S_JALR: begin
          SrcASel   = (state == S_JAL);
          SrcBSel   = 2'b01;
          ResultSrc = 2'b10;
          RegWrite  = 1'b1;
          PCWrite   = 1'b1;
          PCSrc     = 1'b1;
        end
        S_LUI: begin
          ResultSrc = 2'b11;
          RegWrite  = 1'b1;
          PCWrite   = 1'b1;
        end
        S_ILLEGAL: begin
          IllegalInstr = 1'b1;
          PCWrite      = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef INSTRET_CNT_EN
  logic [31:0] instret_q;

  always_ff @(posedge clk) begin
    if (reset)
      instret_q <= '0;
    else if (PCWrite)
      instret_q <= instret_q + 32'd1;
  end

  assign InstRet = instret_q;
`else
  assign InstRet = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm.
// Stimulus queues per-cycle expectations; a negedge monitor checks them.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  Opcode;
  logic [2:0]  Funct3;
  logic        ALUZero;
  logic        ALULessThan;
  logic        ALULessThanU;
  logic        MemReady;
  logic        SrcASel;
  logic [1:0]  SrcBSel;
  logic [1:0]  ALUCtl;
  logic [1:0]  ResultSrc;
  logic        AdrSrc;
  logic        MemRead;
  logic        MemWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic        PCWrite;
  logic        PCSrc;
  logic        IllegalInstr;
  logic [31:0] InstRet;

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk          (clk),
    .reset        (reset),
    .Opcode       (Opcode),
    .Funct3       (Funct3),
    .ALUZero      (ALUZero),
    .ALULessThan  (ALULessThan),
    .ALULessThanU (ALULessThanU),
    .MemReady     (MemReady),
    .SrcASel      (SrcASel),
    .SrcBSel      (SrcBSel),
    .ALUCtl       (ALUCtl),
    .ResultSrc    (ResultSrc),
    .AdrSrc       (AdrSrc),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .IRWrite      (IRWrite),
    .RegWrite     (RegWrite),
    .PCWrite      (PCWrite),
    .PCSrc        (PCSrc),
    .IllegalInstr (IllegalInstr),
    .InstRet      (InstRet)
  );

  typedef struct {
    logic [14:0] o;
    logic [31:0] ir;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cnt    = 0;

  // {SrcA, SrcB, ALUCtl, Result, Adr, MRd, MWr, IRW, RegW, PCW, PCSrc, Ill}
  function automatic logic [14:0] mk(
    input logic a, input logic [1:0] b, input logic [1:0] alu,
    input logic [1:0] res, input logic adr, input logic mr,
    input logic mw, input logic irw, input logic rw,
    input logic pcw, input logic pcs, input logic ill);
    return {a, b, alu, res, adr, mr, mw, irw, rw, pcw, pcs, ill};
  endfunction

  localparam logic [14:0] V_IDLE  = '0;
  localparam logic [14:0] V_FW    = 15'b0_00_00_00_0_1_0_0_0_0_0_0;
  localparam logic [14:0] V_FR    = 15'b0_00_00_00_0_1_0_1_0_0_0_0;
  localparam logic [14:0] V_DEC   = '0;
  localparam logic [14:0] V_EXR   = 15'b0_00_10_00_0_0_0_0_0_0_0_0;
  localparam logic [14:0] V_EXI   = 15'b0_01_10_00_0_0_0_0_0_0_0_0;
  localparam logic [14:0] V_MADR  = 15'b0_01_00_00_0_0_0_0_0_0_0_0;
  localparam logic [14:0] V_MRD   = 15'b0_00_00_00_1_1_0_0_0_0_0_0;
  localparam logic [14:0] V_MWB   = 15'b0_00_00_01_0_0_0_0_1_1_0_0;
  localparam logic [14:0] V_MWRW  = 15'b0_00_00_00_1_0_1_0_0_0_0_0;
  localparam logic [14:0] V_MWRR  = 15'b0_00_00_00_1_0_1_0_0_1_0_0;
  localparam logic [14:0] V_ALUWB = 15'b0_00_00_00_0_0_0_0_1_1_0_0;
  localparam logic [14:0] V_AUIPC = 15'b1_01_00_00_0_0_0_0_0_0_0_0;
  localparam logic [14:0] V_BRC   = 15'b0_00_01_00_0_0_0_0_0_0_0_0;
  localparam logic [14:0] V_BRCX  = 15'b0_00_01_00_0_0_0_0_0_0_0_1;
  localparam logic [14:0] V_BRT0  = 15'b1_01_00_00_0_0_0_0_0_1_0_0;
  localparam logic [14:0] V_BRT1  = 15'b1_01_00_00_0_0_0_0_0_1_1_0;
  localparam logic [14:0] V_JAL   = 15'b1_01_00_10_0_0_0_0_1_1_1_0;
  localparam logic [14:0] V_JALR  = 15'b0_01_00_10_0_0_0_0_1_1_1_0;
  localparam logic [14:0] V_LUI   = 15'b0_00_00_11_0_0_0_0_1_1_0_0;
  localparam logic [14:0] V_ILL   = 15'b0_00_00_00_0_0_0_0_0_1_0_1;

  logic [14:0] act;
  assign act = mk(SrcASel, SrcBSel, ALUCtl, ResultSrc, AdrSrc, MemRead,
                  MemWrite, IRWrite, RegWrite, PCWrite, PCSrc, IllegalInstr);

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (act !== e.o) begin
        n_fail++;
        $display("FAIL %s outputs: got %b want %b", e.name, act, e.o);
      end
      n_cmp++;
      if (InstRet !== e.ir) begin
        n_fail++;
        $display("FAIL %s InstRet: got %0d want %0d", e.name, InstRet, e.ir);
      end
    end
  end

  task automatic step(input logic rst, input logic [6:0] op,
                      input logic [2:0] f3, input logic z, input logic lt,
                      input logic ltu, input logic mr,
                      input logic [14:0] ev, input string nm);
    exp_t e;
    reset        = rst;
    Opcode       = op;
    Funct3       = f3;
    ALUZero      = z;
    ALULessThan  = lt;
    ALULessThanU = ltu;
    MemReady     = mr;
    e.o    = ev;
    e.name = nm;
`ifdef INSTRET_CNT_EN
    e.ir = cnt;
`else
    e.ir = 32'd0;
`endif
    q.push_back(e);
    if (rst)
      cnt = 0;
    else if (ev[2])
      cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic plain(input logic [6:0] op, input logic [2:0] f3,
                       input logic [14:0] ev, input string nm);
    step(1'b0, op, f3, 1'b0, 1'b0, 1'b0, 1'b1, ev, nm);
  endtask

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] RR = 7'b0110011;
  localparam logic [6:0] RI = 7'b0010011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] BX = 7'b1111111;

  task automatic branch(input logic [2:0] f3, input logic z,
                        input logic lt, input logic ltu,
                        input logic [14:0] vc, input logic [14:0] vt,
                        input string nm);
    plain(BR, f3, V_FR, {nm, "_fetch"});
    plain(BR, f3, V_DEC, {nm, "_dec"});
    step(1'b0, BR, f3, z, lt, ltu, 1'b1, vc, {nm, "_cmp"});
    // flip flags so only the latched decision can set PCSrc
    step(1'b0, BR, f3, !z, !lt, !ltu, 1'b1, vt, {nm, "_tgt"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    Opcode = '0;
    Funct3 = '0;
    ALUZero = 1'b0;
    ALULessThan = 1'b0;
    ALULessThanU = 1'b0;
    MemReady = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, '0, '0, 0, 0, 0, 1, V_IDLE, "rst1");
    step(1'b1, '0, '0, 0, 0, 0, 1, V_IDLE, "rst2");
    step(1'b0, '0, '0, 0, 0, 0, 1, V_IDLE, "idle");

    plain(RR, 3'b000, V_FR, "add_fetch");
    plain(RR, 3'b000, V_DEC, "add_dec");
    plain(RR, 3'b000, V_EXR, "add_exec");
    plain(RR, 3'b000, V_ALUWB, "add_wb");

    plain(RI, 3'b000, V_FR, "addi_fetch");
    plain(RI, 3'b000, V_DEC, "addi_dec");
    plain(RI, 3'b000, V_EXI, "addi_exec");
    plain(RI, 3'b000, V_ALUWB, "addi_wb");

    plain(LD, 3'b010, V_FR, "lw_fetch");
    plain(LD, 3'b010, V_DEC, "lw_dec");
    plain(LD, 3'b010, V_MADR, "lw_adr");
    step(1'b0, LD, 3'b010, 0, 0, 0, 0, V_MRD, "lw_rd_w1");
    step(1'b0, LD, 3'b010, 0, 0, 0, 0, V_MRD, "lw_rd_w2");
    plain(LD, 3'b010, V_MRD, "lw_rd");
    plain(LD, 3'b010, V_MWB, "lw_wb");

    step(1'b0, ST, 3'b010, 0, 0, 0, 0, V_FW, "sw_fetch_w");
    plain(ST, 3'b010, V_FR, "sw_fetch");
    plain(ST, 3'b010, V_DEC, "sw_dec");
    plain(ST, 3'b010, V_MADR, "sw_adr");
    plain(ST, 3'b010, V_MWRR, "sw_wr");

    branch(3'b001, 1'b0, 1'b0, 1'b0, V_BRC, V_BRT1, "bne_t");
    branch(3'b001, 1'b1, 1'b0, 1'b0, V_BRC, V_BRT0, "bne_nt");
    branch(3'b110, 1'b0, 1'b0, 1'b1, V_BRC, V_BRT1, "bltu_t");
    branch(3'b101, 1'b0, 1'b1, 1'b0, V_BRC, V_BRT0, "bge_nt");
    branch(3'b010, 1'b1, 1'b1, 1'b1, V_BRCX, V_BRT0, "br_bad");

    plain(7'b1101111, '0, V_FR, "jal_fetch");
    plain(7'b1101111, '0, V_DEC, "jal_dec");
    plain(7'b1101111, '0, V_JAL, "jal");

    plain(7'b1100111, '0, V_FR, "jalr_fetch");
    plain(7'b1100111, '0, V_DEC, "jalr_dec");
    plain(7'b1100111, '0, V_JALR, "jalr");

    plain(7'b0110111, '0, V_FR, "lui_fetch");
    plain(7'b0110111, '0, V_DEC, "lui_dec");
    plain(7'b0110111, '0, V_LUI, "lui");

    plain(7'b0010111, '0, V_FR, "auipc_fetch");
    plain(7'b0010111, '0, V_DEC, "auipc_dec");
    plain(7'b0010111, '0, V_AUIPC, "auipc_exec");
    plain(7'b0010111, '0, V_ALUWB, "auipc_wb");

    plain(BX, '0, V_FR, "ill_fetch");
    plain(BX, '0, V_DEC, "ill_dec");
    plain(BX, '0, V_ILL, "ill");
    plain(BX, '0, V_FR, "ill_next_fetch");
    plain(BX, '0, V_DEC, "ill2_dec");
    plain(BX, '0, V_ILL, "ill2");

    plain(ST, 3'b010, V_FR, "swr_fetch");
    plain(ST, 3'b010, V_DEC, "swr_dec");
    plain(ST, 3'b010, V_MADR, "swr_adr");
    step(1'b0, ST, 3'b010, 0, 0, 0, 0, V_MWRW, "swr_wait");
    step(1'b1, ST, 3'b010, 0, 0, 0, 0, V_IDLE, "swr_reset");
    step(1'b0, ST, 3'b010, 0, 0, 0, 0, V_IDLE, "post_rst_idle");
    step(1'b0, 7'b0110111, '0, 0, 0, 0, 0, V_FW, "rec_fetch_w");
    plain(7'b0110111, '0, V_FR, "rec_fetch");
    plain(7'b0110111, '0, V_DEC, "rec_dec");
    plain(7'b0110111, '0, V_LUI, "rec_lui");
    plain(7'b0110111, '0, V_FR, "rec_next");

    @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
